// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants: engine states, mode codes and S-box tables.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_FWD  = 1'b0;
  localparam logic MODE_INV  = 1'b1;
  localparam int   AES_BYTES = 16;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_dual.sv
// rtl/aes_sbox_dual.sv - one combinational S-box lane, forward or inverse per mode.
module aes_sbox_dual
  import aes_pkg::*;
(
  input  logic [7:0] in,
  input  logic       mode,
  output logic [7:0] out
);

  assign out = (mode == MODE_INV) ? SBOX_INV[in] : SBOX_FWD[in];

endmodule

// File: rtl/sub_byte_engine.sv
// rtl/sub_byte_engine.sv - time-multiplexed SubBytes/InvSubBytes engine.
// LANES bytes are substituted per cycle, ascending byte order, over 16/LANES cycles.
module sub_byte_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  localparam int NCYC = AES_BYTES / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_byte_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [0:127]    src;
  logic [0:127]    res;
  logic            blk_mode;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];

  // Lane j always serves byte cnt*LANES+j of the latched block.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_in[j] = src[(int'(cnt) * LANES + j) * 8 +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_dual u_sbox (
      .in   (lane_in[g]),
      .mode (blk_mode),
      .out  (lane_out[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      src       <= '0;
      res       <= '0;
      blk_mode  <= MODE_FWD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src      <= in_data;
            blk_mode <= in_mode;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          for (int j = 0; j < LANES; j++) begin
            res[(int'(cnt) * LANES + j) * 8 +: 8] <= lane_out[j];
          end
          if (cnt == CW'(NCYC - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE only; the next accept needs a fresh cycle.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = res;

endmodule

// File: tb/tb_sub_byte_engine.sv
// tb/tb_sub_byte_engine.sv - self-checking bench for sub_byte_engine over all LANES values.
module tb_sub_byte_engine;

  localparam int NDUT = 5;  // dut d has LANES = 1 << d

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid_a  [NDUT];
  logic         in_ready_a  [NDUT];
  logic [0:127] in_data_a   [NDUT];
  logic         in_mode_a   [NDUT];
  logic         out_valid_a [NDUT];
  logic         out_ready_a [NDUT];
  logic [0:127] out_data_a  [NDUT];
  logic         busy_a      [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sub_byte_engine #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_data   (in_data_a[g]),
      .in_mode   (in_mode_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_data  (out_data_a[g]),
      .busy      (busy_a[g])
    );
  end

  // Reference S-boxes derived from GF(2^8) inversion plus the AES affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  task automatic build_model;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      end
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      m_fwd[x] = s;
      m_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [0:127] ref_block(input logic [0:127] data, input logic mode);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = mode ? m_inv[data[8*i +: 8]] : m_fwd[data[8*i +: 8]];
    end
    return r;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one accept; returns #1 after the accepting edge.
  task automatic start_block(input int d, input logic [0:127] data, input logic mode);
    @(negedge clk);
    in_valid_a[d] = 1'b1;
    in_data_a[d]  = data;
    in_mode_a[d]  = mode;
    @(posedge clk);
    #1;
    in_valid_a[d] = 1'b0;
  endtask

  // Counts edges after accept until out_valid is seen at a falling edge.
  task automatic wait_done(input int d, output int lat, output bit timeout);
    lat = 0;
    timeout = 1'b0;
    forever begin
      if (lat >= 40) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid_a[d]) break;
    end
  endtask

  task automatic finish_block(input int d);
    @(negedge clk);
    out_ready_a[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[d] = 1'b0;
  endtask

  task automatic do_block(input int d, input logic [0:127] data, input logic mode,
                          output logic [0:127] got, output int lat, output bit timeout);
    start_block(d, data, mode);
    wait_done(d, lat, timeout);
    got = out_data_a[d];
    finish_block(d);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if (in_ready_a[d] !== 1'b1 || out_valid_a[d] !== 1'b0 || busy_a[d] !== 1'b0 ||
          out_data_a[d] !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b busy=%b out_data=%h, required 1 0 0 0",
                 d, in_ready_a[d], out_valid_a[d], busy_a[d], out_data_a[d]);
      end
    end
  endtask

  task automatic test_vectors;
    logic [0:127] vin [4];
    logic [0:127] vexp [4];
    logic         vmode [4];
    logic [0:127] got;
    int lat;
    bit to;
    vin[0] = 128'h000102030405060708090a0b0c0d0e0f; vmode[0] = 1'b0;
    vexp[0] = 128'h637c777bf26b6fc53001672bfed7ab76;
    vin[1] = 128'h637c777bf26b6fc53001672bfed7ab76; vmode[1] = 1'b1;
    vexp[1] = 128'h000102030405060708090a0b0c0d0e0f;
    vin[2] = {16{8'h63}}; vmode[2] = 1'b1; vexp[2] = 128'h0;
    vin[3] = {16{8'hed}}; vmode[3] = 1'b1; vexp[3] = {16{8'h53}};
    for (int v = 0; v < 4; v++) begin
      do_block(2, vin[v], vmode[v], got, lat, to);
      n_checks++;
      if (to || got !== vexp[v]) begin
        n_fail++;
        $display("FAIL vector%0d_data: got %h, required %h (timeout=%b)", v, got, vexp[v], to);
      end
      n_checks++;
      if (lat != 4) begin
        n_fail++;
        $display("FAIL vector%0d_latency: got %0d cycles, required 4", v, lat);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [0:127] data = rand128();
    logic [0:127] expd;
    int lat;
    bit to;
    expd = ref_block(data, 1'b0);
    start_block(2, data, 1'b0);
    #2;
    n_checks++;
    if (busy_a[2] !== 1'b1 || in_ready_a[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_flag: busy=%b in_ready=%b, required 1 0", busy_a[2], in_ready_a[2]);
    end
    wait_done(2, lat, to);
    in_valid_a[2] = 1'b1;
    in_data_a[2]  = rand128();
    in_mode_a[2]  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (to || out_valid_a[2] !== 1'b1 || out_data_a[2] !== expd || in_ready_a[2] !== 1'b0 ||
          busy_a[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold c%0d: out_valid=%b in_ready=%b busy=%b data=%h, required 1 0 0 %h",
                 c, out_valid_a[2], in_ready_a[2], busy_a[2], out_data_a[2], expd);
      end
    end
    in_valid_a[2]  = 1'b0;
    out_ready_a[2] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid_a[2] !== 1'b0 || in_ready_a[2] !== 1'b1 || out_data_a[2] !== expd) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b data=%h, required 0 1 %h",
               out_valid_a[2], in_ready_a[2], out_data_a[2], expd);
    end
    @(negedge clk);
    n_checks++;
    if (busy_a[2] !== 1'b0 || in_ready_a[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_no_accept: busy=%b in_ready=%b, required 0 1", busy_a[2], in_ready_a[2]);
    end
  endtask

  task automatic test_async_reset;
    logic [0:127] data = rand128();
    logic [0:127] got;
    int lat;
    bit to;
    start_block(2, rand128(), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid_a[2] !== 1'b0 || in_ready_a[2] !== 1'b1 || busy_a[2] !== 1'b0 ||
        out_data_a[2] !== 128'h0) begin
      n_fail++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b busy=%b data=%h, required 0 1 0 0",
               out_valid_a[2], in_ready_a[2], busy_a[2], out_data_a[2]);
    end
    #2;
    rst = 1'b0;
    do_block(2, data, 1'b1, got, lat, to);
    n_checks++;
    if (to || got !== ref_block(data, 1'b1) || lat != 4) begin
      n_fail++;
      $display("FAIL after_reset_block: got %h lat %0d, required %h lat 4", got, lat, ref_block(data, 1'b1));
    end
  endtask

  task automatic test_lane_sweep;
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 6; k++) begin
        logic [0:127] data = rand128();
        logic         mode = 1'($urandom_range(0, 1));
        logic [0:127] got;
        int lat;
        bit to;
        do_block(d, data, mode, got, lat, to);
        n_checks++;
        if (to || got !== ref_block(data, mode) || lat != (16 >> d)) begin
          n_fail++;
          $display("FAIL sweep_lanes%0d_blk%0d: got %h lat %0d, required %h lat %0d",
                   1 << d, k, got, lat, ref_block(data, mode), 16 >> d);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    localparam int NB = 8;
    for (int d = 0; d < NDUT; d++) begin
      logic [0:127] q_exp [$];
      logic [0:127] cur;
      int acc = 0;
      int outs = 0;
      int last = -1;
      int cyc = 0;
      bit acc_now;
      bit hs_now;
      cur = rand128();
      @(negedge clk);
      in_valid_a[d]  = 1'b1;
      in_data_a[d]   = cur;
      in_mode_a[d]   = 1'b0;
      out_ready_a[d] = 1'b1;
      while ((acc < NB || outs < NB) && cyc < 400) begin
        acc_now = in_valid_a[d] && in_ready_a[d];
        hs_now  = out_valid_a[d];
        if (hs_now) begin
          n_checks++;
          if (q_exp.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_lanes%0d_extra: unexpected block %h, required none", 1 << d, out_data_a[d]);
          end else begin
            logic [0:127] e = q_exp.pop_front();
            if (out_data_a[d] !== e) begin
              n_fail++;
              $display("FAIL b2b_lanes%0d_data%0d: got %h, required %h", 1 << d, outs, out_data_a[d], e);
            end
          end
          outs++;
        end
        if (acc_now) begin
          q_exp.push_back(ref_block(cur, in_mode_a[d]));
          if (last >= 0) begin
            n_checks++;
            if (cyc - last != (16 >> d) + 2) begin
              n_fail++;
              $display("FAIL b2b_lanes%0d_interval: got %0d cycles, required %0d",
                       1 << d, cyc - last, (16 >> d) + 2);
            end
          end
          last = cyc;
        end
        @(posedge clk);
        #1;
        if (acc_now) begin
          acc++;
          if (acc < NB) begin
            cur = rand128();
            in_data_a[d] = cur;
            in_mode_a[d] = 1'(acc % 2);
          end else begin
            in_valid_a[d] = 1'b0;
          end
        end
        cyc++;
        @(negedge clk);
      end
      in_valid_a[d]  = 1'b0;
      out_ready_a[d] = 1'b0;
      n_checks++;
      if (outs != NB || q_exp.size() != 0) begin
        n_fail++;
        $display("FAIL b2b_lanes%0d_count: got %0d outputs %0d pending, required %0d outputs 0 pending",
                 1 << d, outs, q_exp.size(), NB);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      in_valid_a[d]  = 1'b0;
      in_data_a[d]   = '0;
      in_mode_a[d]   = 1'b0;
      out_ready_a[d] = 1'b0;
    end
    build_model();
    test_reset();
    test_vectors();
    test_backpressure();
    test_async_reset();
    test_lane_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
